// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter sharing one 8-lane byte-wide DRAM interface.
// Latches one request per port, issues it, gathers lane completions and returns a single response beat.
module dram_arbiter #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [LANES-1:0]                   p0_en,
    input  logic                               p0_rdwr,
    input  logic [LANES-1:0][ADDR_W-1:0]       p0_addr,
    input  logic [LANES-1:0][7:0]              p0_wdata,
    input  logic [LANES-1:0]                   p1_en,
    input  logic                               p1_rdwr,
    input  logic [LANES-1:0][ADDR_W-1:0]       p1_addr,
    input  logic [LANES-1:0][7:0]              p1_wdata,
    output logic [LANES-1:0]                   p0_valid,
    output logic [LANES-1:0][7:0]              p0_data,
    output logic                               p0_overrun,
    output logic [LANES-1:0]                   p1_valid,
    output logic [LANES-1:0][7:0]              p1_data,
    output logic                               p1_overrun,
    output logic [LANES-1:0]                   dram_en,
    output logic                               dram_rdwr,
    output logic [LANES-1:0][ADDR_W-1:0]       dram_addr,
    output logic [LANES-1:0][7:0]              dram_wdata,
    input  logic [LANES-1:0]                   dram_valid,
    input  logic [LANES-1:0][7:0]              dram_data
);
    localparam int unsigned NPORTS = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                                      state;
    logic [NPORTS-1:0]                           pend;
    logic [NPORTS-1:0]                           overrun;
    logic [NPORTS-1:0][LANES-1:0]                pmask;
    logic [NPORTS-1:0]                           prdwr;
    logic [NPORTS-1:0][LANES-1:0][ADDR_W-1:0]    paddr;
    logic [NPORTS-1:0][LANES-1:0][7:0]           pwdata;
    logic [NPORTS-1:0][LANES-1:0]                resp_valid;
    logic [NPORTS-1:0][LANES-1:0][7:0]           resp_data;

    logic [NPORTS-1:0][LANES-1:0]                req_en;
    logic [NPORTS-1:0]                           req_rdwr;
    logic [NPORTS-1:0][LANES-1:0][ADDR_W-1:0]    req_addr;
    logic [NPORTS-1:0][LANES-1:0][7:0]           req_wdata;

    logic                                        owner;
    logic                                        rr;
    logic                                        grant;
    logic [LANES-1:0]                            done;
    logic [LANES-1:0]                            hit;
    logic [LANES-1:0][7:0]                       cap;

    assign req_en    = {p1_en, p0_en};
    assign req_rdwr  = {p1_rdwr, p0_rdwr};
    assign req_addr  = {p1_addr, p0_addr};
    assign req_wdata = {p1_wdata, p0_wdata};

    assign p0_valid   = resp_valid[0];
    assign p1_valid   = resp_valid[1];
    assign p0_data    = resp_data[0];
    assign p1_data    = resp_data[1];
    assign p0_overrun = overrun[0];
    assign p1_overrun = overrun[1];

    // Grant selection and masked completion lanes for the current owner
    always_comb begin
        grant = pend[1];
        if (pend == 2'b11) begin
            grant = rr;
        end
        hit = dram_valid & pmask[owner];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend       <= '0;
            overrun    <= '0;
            pmask      <= '0;
            prdwr      <= '0;
            paddr      <= '0;
            pwdata     <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            owner      <= 1'b0;
            rr         <= 1'b0;
            done       <= '0;
            cap        <= '0;
            dram_en    <= '0;
            dram_rdwr  <= 1'b1;
            dram_addr  <= '0;
            dram_wdata <= '0;
        end else begin
            // Pending buffers: accept when empty, otherwise drop and flag
            for (int p = 0; p < NPORTS; p++) begin
                if (req_en[p] != '0) begin
                    if (!pend[p]) begin
                        pend[p]   <= 1'b1;
                        pmask[p]  <= req_en[p];
                        prdwr[p]  <= req_rdwr[p];
                        paddr[p]  <= req_addr[p];
                        pwdata[p] <= req_wdata[p];
                    end else begin
                        overrun[p] <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (pend != '0) begin
                        owner      <= grant;
                        dram_en    <= pmask[grant];
                        dram_rdwr  <= prdwr[grant];
                        dram_addr  <= paddr[grant];
                        dram_wdata <= pwdata[grant];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    dram_en <= '0;
                    done    <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (hit[i]) begin
                            cap[i] <= dram_data[i];
                        end
                    end
                    done <= done | hit;
                    // Final lane may land this cycle, so merge it straight into the response
                    if ((done | hit) == pmask[owner]) begin
                        pend[owner]       <= 1'b0;
                        resp_valid[owner] <= pmask[owner];
                        for (int i = 0; i < LANES; i++) begin
                            if (pmask[owner][i]) begin
                                resp_data[owner][i] <= hit[i] ? dram_data[i] : cap[i];
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    resp_valid[owner] <= '0;
                    rr                <= ~owner;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter.
module tb_dram_arbiter;
    localparam int unsigned LANES  = 8;
    localparam int unsigned ADDR_W = 64;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [LANES-1:0]              p0_en, p1_en;
    logic                          p0_rdwr, p1_rdwr;
    logic [LANES-1:0][ADDR_W-1:0]  p0_addr, p1_addr;
    logic [LANES-1:0][7:0]         p0_wdata, p1_wdata;
    logic [LANES-1:0]              p0_valid, p1_valid;
    logic [LANES-1:0][7:0]         p0_data, p1_data;
    logic                          p0_overrun, p1_overrun;
    logic [LANES-1:0]              dram_en;
    logic                          dram_rdwr;
    logic [LANES-1:0][ADDR_W-1:0]  dram_addr;
    logic [LANES-1:0][7:0]         dram_wdata;
    logic [LANES-1:0]              dram_valid;
    logic [LANES-1:0][7:0]         dram_data;

    int unsigned passes = 0;
    int unsigned total  = 0;

    dram_arbiter #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .p0_en(p0_en), .p0_rdwr(p0_rdwr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_en(p1_en), .p1_rdwr(p1_rdwr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_valid(p0_valid), .p0_data(p0_data), .p0_overrun(p0_overrun),
        .p1_valid(p1_valid), .p1_data(p1_data), .p1_overrun(p1_overrun),
        .dram_en(dram_en), .dram_rdwr(dram_rdwr), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_valid(dram_valid), .dram_data(dram_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] mk_data(input logic [7:0] b);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = b + 8'(i);
        return r;
    endfunction

    function automatic logic [511:0] mk_addr(input logic [63:0] b);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = b + 64'(i);
        return r;
    endfunction

    task automatic drive_valid(input logic [7:0] m, input logic [7:0] b);
        dram_valid = m;
        dram_data  = mk_data(b);
    endtask

    // Starts in an IDLE cycle with the request pending; ends in the IDLE cycle after RESP
    task automatic serve_one(input int who, input logic [7:0] mask, input logic [511:0] addr,
                             input logic rdwr, input logic [63:0] wdata,
                             input logic [7:0] dbase, input logic [63:0] exp_data);
        step();
        chk($sformatf("p%0d issue dram_en", who), 512'(dram_en), 512'(mask));
        chk($sformatf("p%0d issue dram_addr", who), 512'(dram_addr), addr);
        chk($sformatf("p%0d issue dram_rdwr", who), 512'(dram_rdwr), 512'(rdwr));
        if (!rdwr) chk($sformatf("p%0d issue dram_wdata", who), 512'(dram_wdata), 512'(wdata));
        step();
        drive_valid(8'hFF, dbase);
        step();
        dram_valid = '0;
        if (who == 0) begin
            chk("p0 resp valid", 512'(p0_valid), 512'(mask));
            chk("p0 resp p1 quiet", 512'(p1_valid), 512'(0));
            if (rdwr) chk("p0 resp data", 512'(p0_data), 512'(exp_data));
        end else begin
            chk("p1 resp valid", 512'(p1_valid), 512'(mask));
            chk("p1 resp p0 quiet", 512'(p0_valid), 512'(0));
            if (rdwr) chk("p1 resp data", 512'(p1_data), 512'(exp_data));
        end
        step();
        chk($sformatf("p%0d valid drop", who), 512'({p1_valid, p0_valid}), 512'(0));
    endtask

    initial begin
        logic [63:0] exp_d;
        logic [63:0] tmp_d;

        reset = 1'b1;
        p0_en = '0; p1_en = '0; p0_rdwr = 1'b1; p1_rdwr = 1'b1;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        dram_valid = '0; dram_data = '0;
        step(); step();
        reset = 1'b0;
        chk("rst dram_en", 512'(dram_en), 512'(0));
        chk("rst dram_rdwr", 512'(dram_rdwr), 512'(1));
        chk("rst dram_addr", 512'(dram_addr), 512'(0));
        chk("rst valids", 512'({p1_valid, p0_valid}), 512'(0));
        chk("rst data", 512'({p1_data, p0_data}), 512'(0));
        chk("rst overrun", 512'({p1_overrun, p0_overrun}), 512'(0));

        // Single read, completion 3 cycles after dram_en
        p0_en = 8'hFF; p0_rdwr = 1'b1; p0_addr = mk_addr(64'h1000);
        step();
        p0_en = '0;
        chk("single no early en", 512'(dram_en), 512'(0));
        step();
        chk("single dram_en", 512'(dram_en), 512'(8'hFF));
        chk("single dram_addr", 512'(dram_addr), mk_addr(64'h1000));
        chk("single dram_rdwr", 512'(dram_rdwr), 512'(1));
        step();
        chk("single dram_en one cycle", 512'(dram_en), 512'(0));
        step(); step();
        drive_valid(8'hFF, 8'hA0);
        step();
        dram_valid = '0;
        chk("single p0_valid", 512'(p0_valid), 512'(8'hFF));
        chk("single p0_data", 512'(p0_data), 512'(mk_data(8'hA0)));
        chk("single p1 quiet", 512'(p1_valid), 512'(0));
        step();
        chk("single valid drop", 512'(p0_valid), 512'(0));

        // Staggered lanes
        p0_en = 8'hFF; p0_addr = mk_addr(64'h2000);
        step();
        p0_en = '0;
        step();
        chk("stag dram_en", 512'(dram_en), 512'(8'hFF));
        step();
        drive_valid(8'h0F, 8'hB0);
        step();
        dram_valid = '0;
        chk("stag no early 1", 512'(p0_valid), 512'(0));
        step();
        chk("stag no early 2", 512'(p0_valid), 512'(0));
        step();
        chk("stag no early 3", 512'(p0_valid), 512'(0));
        step();
        drive_valid(8'hF0, 8'hC0);
        chk("stag no early 4", 512'(p0_valid), 512'(0));
        step();
        dram_valid = '0;
        exp_d = mk_data(8'hB0);
        tmp_d = mk_data(8'hC0);
        exp_d[63:32] = tmp_d[63:32];
        chk("stag p0_valid", 512'(p0_valid), 512'(8'hFF));
        chk("stag p0_data", 512'(p0_data), 512'(exp_d));
        step();
        chk("stag once", 512'(p0_valid), 512'(0));

        // Simultaneous requests from reset: p0 first, then p1
        reset = 1'b1;
        step();
        reset = 1'b0;
        p0_en = 8'hFF; p0_rdwr = 1'b1; p0_addr = mk_addr(64'h3000);
        p1_en = 8'hFF; p1_rdwr = 1'b0; p1_addr = mk_addr(64'h4000); p1_wdata = mk_data(8'h50);
        step();
        p0_en = '0; p1_en = '0;
        serve_one(0, 8'hFF, mk_addr(64'h3000), 1'b1, 64'h0, 8'hD0, mk_data(8'hD0));
        serve_one(1, 8'hFF, mk_addr(64'h4000), 1'b0, mk_data(8'h50), 8'hE0, 64'h0);
        chk("rdwr hold", 512'(dram_rdwr), 512'(0));
        chk("addr hold", 512'(dram_addr), mk_addr(64'h4000));

        // Tie again with rr back at port 0
        p0_en = 8'hFF; p0_addr = mk_addr(64'h3100);
        p1_en = 8'hFF; p1_rdwr = 1'b1; p1_addr = mk_addr(64'h4100);
        step();
        p0_en = '0; p1_en = '0;
        serve_one(0, 8'hFF, mk_addr(64'h3100), 1'b1, 64'h0, 8'hD8, mk_data(8'hD8));
        serve_one(1, 8'hFF, mk_addr(64'h4100), 1'b1, 64'h0, 8'h20, mk_data(8'h20));

        // p0 alone moves rr to port 1, so the next tie goes p1 then p0
        p0_en = 8'hFF; p0_addr = mk_addr(64'h3200);
        step();
        p0_en = '0;
        serve_one(0, 8'hFF, mk_addr(64'h3200), 1'b1, 64'h0, 8'h28, mk_data(8'h28));
        p0_en = 8'hFF; p0_addr = mk_addr(64'h3300);
        p1_en = 8'hFF; p1_addr = mk_addr(64'h4300);
        step();
        p0_en = '0; p1_en = '0;
        serve_one(1, 8'hFF, mk_addr(64'h4300), 1'b1, 64'h0, 8'h30, mk_data(8'h30));
        serve_one(0, 8'hFF, mk_addr(64'h3300), 1'b1, 64'h0, 8'h38, mk_data(8'h38));
        chk("sim no overrun", 512'({p1_overrun, p0_overrun}), 512'(0));

        // Overrun: p1 re-pulses twice while waiting
        p1_en = 8'hFF; p1_addr = mk_addr(64'h5000);
        step();
        p1_en = '0;
        step();
        chk("ovr dram_en", 512'(dram_en), 512'(8'hFF));
        step();
        p1_en = 8'hFF; p1_addr = mk_addr(64'h6000);
        step();
        p1_en = '0;
        chk("ovr flag", 512'(p1_overrun), 512'(1));
        chk("ovr no reissue", 512'(dram_en), 512'(0));
        p1_en = 8'hFF;
        step();
        p1_en = '0;
        chk("ovr sticky", 512'(p1_overrun), 512'(1));
        chk("ovr addr held", 512'(dram_addr), mk_addr(64'h5000));
        drive_valid(8'hFF, 8'h70);
        step();
        dram_valid = '0;
        chk("ovr p1_valid", 512'(p1_valid), 512'(8'hFF));
        chk("ovr p1_data", 512'(p1_data), 512'(mk_data(8'h70)));
        step();
        step();
        chk("ovr single issue", 512'(dram_en), 512'(0));
        chk("ovr still sticky", 512'(p1_overrun), 512'(1));
        chk("ovr p0 clean", 512'(p0_overrun), 512'(0));

        // Chained read: re-pulse in RESP
        p0_en = 8'hFF; p0_addr = mk_addr(64'h1000);
        step();
        p0_en = '0;
        step();
        chk("chain first en", 512'(dram_en), 512'(8'hFF));
        step();
        drive_valid(8'hFF, 8'h80);
        step();
        dram_valid = '0;
        chk("chain first valid", 512'(p0_valid), 512'(8'hFF));
        chk("chain first data", 512'(p0_data), 512'(mk_data(8'h80)));
        p0_en = 8'hFF; p0_addr = mk_addr(64'h1008);
        step();
        p0_en = '0;
        chk("chain no overrun", 512'(p0_overrun), 512'(0));
        serve_one(0, 8'hFF, mk_addr(64'h1008), 1'b1, 64'h0, 8'h90, mk_data(8'h90));
        chk("chain overrun after", 512'(p0_overrun), 512'(0));

        // Partial mask: unmasked lanes ignore dram_valid and keep old bytes
        p0_en = 8'h3C; p0_addr = mk_addr(64'h7000);
        step();
        p0_en = '0;
        exp_d = mk_data(8'h90);
        tmp_d = mk_data(8'h10);
        exp_d[47:16] = tmp_d[47:16];
        serve_one(0, 8'h3C, mk_addr(64'h7000), 1'b1, 64'h0, 8'h10, exp_d);

        // dram_valid during ISSUE is ignored, then reset during WAIT
        p1_en = 8'hFF; p1_addr = mk_addr(64'h8000);
        step();
        p1_en = '0;
        step();
        chk("rstw dram_en", 512'(dram_en), 512'(8'hFF));
        drive_valid(8'hFF, 8'h33);
        step();
        dram_valid = '0;
        step();
        chk("issue valid ignored", 512'(p1_valid), 512'(0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_valid(8'hFF, 8'h44);
        chk("rstw dram_rdwr", 512'(dram_rdwr), 512'(1));
        chk("rstw dram_addr", 512'(dram_addr), 512'(0));
        chk("rstw data", 512'({p1_data, p0_data}), 512'(0));
        chk("rstw overrun", 512'({p1_overrun, p0_overrun}), 512'(0));
        step();
        dram_valid = '0;
        chk("rstw late valid", 512'({p1_valid, p0_valid}), 512'(0));
        chk("rstw pend cleared", 512'(dram_en), 512'(0));
        step();
        chk("rstw still quiet", 512'({p1_valid, p0_valid, dram_en}), 512'(0));
        p1_en = 8'hFF; p1_addr = mk_addr(64'h9000);
        step();
        p1_en = '0;
        serve_one(1, 8'hFF, mk_addr(64'h9000), 1'b1, 64'h0, 8'h55, mk_data(8'h55));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
